phy_clock_sel_ctrl: RTL
=======================

PHY_CLOCK_SEL_CTRL -- requirements
Module: phy_clock_sel_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 4: number of selectable clocks on the downstream clock mux, range 2..8.
REQ-002 SHALL have parameter NUM_CLOCK_SEL, default 2: width of the select bus, with 2^NUM_CLOCK_SEL >= NUM_CLOCKS.
REQ-003 SHALL have parameter RESET_SEL, default 0: selection index applied at reset, less than NUM_CLOCKS.
REQ-004 SHALL have parameter GATE_CYCLES, default 4: gated cycles before the select changes, range 1..255.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 8: gated cycles after the select changes, range 1..255.
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port: clk, input, 1 bit, always-running control clock.
REQ-008 SHALL have port: reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port: sel_req_valid, input, 1 bit, switch request valid.
REQ-010 SHALL have port: sel_req, input, NUM_CLOCK_SEL bits, requested clock index.
REQ-011 SHALL have port: sel_req_ready, output, 1 bit, controller can accept a request.
REQ-012 SHALL have port: clk_sel, output, NUM_CLOCK_SEL bits, registered select driving the clock mux.
REQ-013 SHALL have port: clk_gate_en, output, 1 bit, registered enable for the downstream clock gate; 0 = gated.
REQ-014 SHALL have port: sel_done, output, 1 bit, one-cycle pulse when a switch completes.
REQ-015 SHALL have port: sel_err, output, 1 bit, one-cycle pulse when a request is rejected.

Function
REQ-016 SHALL use states IDLE, GATE_OFF and SETTLE.
REQ-017 SHALL drive sel_req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request when sel_req_valid and sel_req_ready are both 1 in the same cycle (acceptance cycle T).
REQ-019 SHALL sample sel_req only at acceptance and ignore it at all other times.
REQ-020 Valid request at T: enter GATE_OFF, with clk_gate_en = 0 from cycle T+1.
REQ-021 GATE_OFF SHALL last GATE_CYCLES cycles (T+1..T+G). On exit, clk_sel SHALL load the accepted index, visible from T+G+1, and the block SHALL enter SETTLE.
REQ-022 SETTLE SHALL last SETTLE_CYCLES cycles (T+G+1..T+G+S). Then, in cycle T+G+S+1: state = IDLE, clk_gate_en = 1, sel_done = 1 for exactly one cycle, sel_req_ready = 1.
REQ-023 clk_gate_en SHALL remain 0 continuously from T+1 to T+G+S, and clk_sel SHALL change only while clk_gate_en = 0.
REQ-024 A request with sel_req >= NUM_CLOCKS SHALL be accepted and rejected: sel_err = 1 at T+1, state stays IDLE, clk_sel and clk_gate_en unchanged, no sel_done.
REQ-025 Back-to-back requests SHALL be allowed: a new request may be accepted in the same cycle sel_done is high.
REQ-026 sel_done and sel_err SHALL never be high in the same cycle.
REQ-027 Phase counters SHALL be 8 bits and SHALL NOT wrap within a phase.

Reset
REQ-028 On reset_n low, asynchronously: state = IDLE, clk_sel = RESET_SEL, clk_gate_en = 1, sel_req_ready = 1, sel_done = 0, sel_err = 0, counters = 0.
REQ-029 Reset asserted mid-switch SHALL abort the switch immediately; no sel_done SHALL follow reset release.
REQ-030 Reset deassertion SHALL be consumed synchronously; the first request SHALL be acceptable on the first clk edge after release.

Configuration
REQ-031 Macro PHY_CLK_SEL_SAME_SKIP_EN defined: a valid request whose index equals the current clk_sel SHALL skip GATE_OFF and SETTLE; sel_done = 1 at T+1, clk_gate_en stays 1, state stays IDLE.
REQ-032 Macro PHY_CLK_SEL_SAME_SKIP_EN undefined: a same-index request SHALL run the full sequence per REQ-020..REQ-022.

Verification
REQ-033 Reset release, no requests -> clk_sel = 0, clk_gate_en = 1, sel_req_ready = 1, sel_done = 0 indefinitely.
REQ-034 Defaults, request sel_req = 2 accepted at cycle 10 -> clk_gate_en = 0 for cycles 11..22; clk_sel = 2 from cycle 15; clk_gate_en = 1 and sel_done pulse at cycle 23.
REQ-035 Request sel_req = 5 with NUM_CLOCKS = 4 at cycle 10 -> sel_err pulse at cycle 11; clk_sel and clk_gate_en unchanged; ready stays 1.
REQ-036 Request sel_req = 3 at cycle 10, reset_n low at cycle 17 -> immediately clk_sel = 0 and clk_gate_en = 1; no sel_done after release.
REQ-037 Request sel_req = 0 while clk_sel = 0 -> with macro: sel_done at T+1, gate never drops; without macro: full 12-cycle gated sequence, then sel_done at T+13.
REQ-038 Second request held valid at cycle 23, during the sel_done pulse -> accepted at 23; clk_gate_en low from 24; no lost or duplicate sel_done.

Source files
------------

// File: rtl/phy_clock_sel_ctrl.sv
// Glitch-free clock-select sequencer: gates the downstream clock, switches the mux select, settles, ungates.
// Optional PHY_CLK_SEL_SAME_SKIP_EN: a request for the already-selected index completes at once without gating.
module phy_clock_sel_ctrl #(
  parameter int unsigned NUM_CLOCKS    = 4,
  parameter int unsigned NUM_CLOCK_SEL = 2,
  parameter int unsigned RESET_SEL     = 0,
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sel_req_valid,
  input  logic [NUM_CLOCK_SEL-1:0] sel_req,
  output logic                     sel_req_ready,
  output logic [NUM_CLOCK_SEL-1:0] clk_sel,
  output logic                     clk_gate_en,
  output logic                     sel_done,
  output logic                     sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    GATE_OFF,
    SETTLE
  } state_t;

  localparam logic [7:0]               GATE_LAST   = 8'(GATE_CYCLES - 1);
  localparam logic [7:0]               SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [NUM_CLOCK_SEL:0]   CLK_LIMIT   = (NUM_CLOCK_SEL + 1)'(NUM_CLOCKS);
  localparam logic [NUM_CLOCK_SEL-1:0] RESET_IDX   = NUM_CLOCK_SEL'(RESET_SEL);

  state_t                   state;
  state_t                   state_nxt;
  logic [7:0]               cnt;
  logic [7:0]               cnt_nxt;
  logic [NUM_CLOCK_SEL-1:0] pend_sel;
  logic [NUM_CLOCK_SEL-1:0] pend_sel_nxt;
  logic [NUM_CLOCK_SEL-1:0] clk_sel_nxt;
  logic                     gate_nxt;
  logic                     done_nxt;
  logic                     err_nxt;
  logic                     accept;
  logic                     req_in_range;

  assign sel_req_ready = (state == IDLE);
  assign accept        = sel_req_valid && sel_req_ready;
  assign req_in_range  = ({1'b0, sel_req} < CLK_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_sel    <= RESET_IDX;
      clk_sel     <= RESET_IDX;
      clk_gate_en <= 1'b1;
      sel_done    <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend_sel    <= pend_sel_nxt;
      clk_sel     <= clk_sel_nxt;
      clk_gate_en <= gate_nxt;
      sel_done    <= done_nxt;
      sel_err     <= err_nxt;
    end
  end

  // The select register only loads on the GATE_OFF->SETTLE edge, so the mux never switches ungated.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_sel_nxt = pend_sel;
    clk_sel_nxt  = clk_sel;
    gate_nxt     = clk_gate_en;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        gate_nxt = 1'b1;
        if (accept) begin
          if (!req_in_range) begin
            err_nxt = 1'b1;
          end
`ifdef PHY_CLK_SEL_SAME_SKIP_EN
          else if (sel_req == clk_sel) begin
            done_nxt = 1'b1;
          end
`endif
          else begin
            state_nxt    = GATE_OFF;
            pend_sel_nxt = sel_req;
            gate_nxt     = 1'b0;
            cnt_nxt      = '0;
          end
        end
      end
      GATE_OFF: begin
        gate_nxt = 1'b0;
        if (cnt == GATE_LAST) begin
          state_nxt   = SETTLE;
          clk_sel_nxt = pend_sel;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SETTLE: begin
        gate_nxt = 1'b0;
        if (cnt == SETTLE_LAST) begin
          state_nxt = IDLE;
          gate_nxt  = 1'b1;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gate_nxt  = 1'b1;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
